wave_sum_tree: RTL and testbench

WAVE_SUM_TREE -- requirements
Module: wave_sum_tree

---
 rtl/wave_sum_tree.sv | 193 +++++++++++++++++++
 tb/tb_wave_sum_tree.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sum_tree.sv
// wave_sum_tree: pipelined signed adder tree over NUM_CH channels.
// Stage 0 registers the masked samples. Each tree level registers pairwise sums
// one bit wider than the level before it. A final stage saturates or wraps the
// exact sum to OUT_W bits and tracks out-of-range events.
// Latency from an accepted beat to out_valid is log2(NUM_CH)+1 cycles.
// A new beat can be accepted every cycle; there is no backpressure.
module wave_sum_tree #(
  parameter int unsigned NUM_CH   = 64,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned OUT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         sat_en,
  input  logic                         clr_ovf,
  output logic                         out_valid,
  output logic [OUT_W-1:0]             result,
  output logic                         overflow,
  output logic [7:0]                   ovf_count
);

  localparam int unsigned LOG2   = $clog2(NUM_CH);
  // Width that holds the full sum exactly.
  localparam int unsigned W_FULL = SAMPLE_W + LOG2;

  // Representable range of an OUT_W-bit signed result, expressed at full width.
  localparam logic signed [W_FULL-1:0] MAX_V =
    {{(W_FULL-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [W_FULL-1:0] MIN_V =
    {{(W_FULL-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  localparam logic [OUT_W-1:0] CLAMP_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] CLAMP_LO = {1'b1, {(OUT_W-1){1'b0}}};

  // Reject illegal parameterisations at elaboration time.
  if (NUM_CH < 2 || NUM_CH > 256 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("wave_sum_tree: NUM_CH must be a power of two in 2..256");
  end
  if (OUT_W < 2 || OUT_W > W_FULL) begin : g_bad_out_w
    $error("wave_sum_tree: OUT_W must be in 2..SAMPLE_W+log2(NUM_CH)");
  end

  // ---------------------------------------------------------------------------
  // Pipeline: level 0 holds masked samples, level lv holds NUM_CH>>lv partial
  // sums of width SAMPLE_W+lv. Each level carries its own valid and sat flag so
  // a beat's saturation mode travels with it.
  // ---------------------------------------------------------------------------
  for (genvar lv = 0; lv <= LOG2; lv++) begin : g_lvl
    localparam int unsigned NN = NUM_CH >> lv;
    localparam int unsigned WW = SAMPLE_W + lv;

    logic signed [WW-1:0] r_sum [NN];
    logic                 r_vld;
    logic                 r_sat;

    if (lv == 0) begin : g_in
      // Capture the beat; disabled channels contribute zero. Hold on bubbles.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= 1'b0;
          r_sat <= 1'b0;
          for (int unsigned i = 0; i < NN; i++) begin
            r_sum[i] <= '0;
          end
        end else begin
          r_vld <= in_valid;
          if (in_valid) begin
            r_sat <= sat_en;
            for (int unsigned i = 0; i < NN; i++) begin
              r_sum[i] <= ch_enable[i] ? samples[i*SAMPLE_W +: SAMPLE_W] : '0;
            end
          end
        end
      end
    end else begin : g_add
      localparam int unsigned PW = WW - 1;

      logic signed [WW-1:0] w_sum [NN];

      // Sign-extend each operand by one bit so the pairwise sum never overflows.
      always_comb begin
        for (int unsigned i = 0; i < NN; i++) begin
          w_sum[i] = {g_lvl[lv-1].r_sum[2*i][PW-1],   g_lvl[lv-1].r_sum[2*i]}
                   + {g_lvl[lv-1].r_sum[2*i+1][PW-1], g_lvl[lv-1].r_sum[2*i+1]};
        end
      end

      // Register this level's sums; valid always advances, data only on valid.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld <= 1'b0;
          r_sat <= 1'b0;
          for (int unsigned i = 0; i < NN; i++) begin
            r_sum[i] <= '0;
          end
        end else begin
          r_vld <= g_lvl[lv-1].r_vld;
          if (g_lvl[lv-1].r_vld) begin
            r_sat <= g_lvl[lv-1].r_sat;
            for (int unsigned i = 0; i < NN; i++) begin
              r_sum[i] <= w_sum[i];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: range check, saturate or wrap, overflow bookkeeping.
  // ---------------------------------------------------------------------------
  logic signed [W_FULL-1:0] w_s;
  logic                     w_vld;
  logic                     w_sat;
  logic                     w_hi;
  logic                     w_lo;
  logic                     w_event;
  logic [OUT_W-1:0]         w_res_next;
  logic [7:0]               w_cnt_next;

  assign w_s   = g_lvl[LOG2].r_sum[0];
  assign w_vld = g_lvl[LOG2].r_vld;
  assign w_sat = g_lvl[LOG2].r_sat;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_result;
  logic             r_overflow;
  logic [7:0]       r_ovf_count;

  // Classify the full sum and pick the saturated or wrapped result.
  always_comb begin
    w_hi       = (w_s > MAX_V);
    w_lo       = (w_s < MIN_V);
    w_event    = w_vld & (w_hi | w_lo);
    w_res_next = w_s[OUT_W-1:0];
    if (w_sat && w_hi) begin
      w_res_next = CLAMP_HI;
    end else if (w_sat && w_lo) begin
      w_res_next = CLAMP_LO;
    end
  end

  // Next overflow count: an event beats a simultaneous clear and restarts at 1.
  always_comb begin
    w_cnt_next = r_ovf_count;
    if (w_event) begin
      if (clr_ovf) begin
        w_cnt_next = 8'd1;
      end else if (r_ovf_count != 8'hff) begin
        w_cnt_next = r_ovf_count + 8'd1;
      end
    end else if (clr_ovf) begin
      w_cnt_next = 8'd0;
    end
  end

  // Output registers; result holds its last value between valid beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_out_valid <= w_vld;
      if (w_vld) begin
        r_result <= w_res_next;
      end
    end
  end

  // Sticky overflow flag and saturating event counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= 8'd0;
    end else begin
      r_ovf_count <= w_cnt_next;
      if (w_event) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_wave_sum_tree.sv
// Bench for wave_sum_tree with NUM_CH=4, SAMPLE_W=16, OUT_W=16 (latency 3).
// A behavioural model sums channels as plain integers, delays them by the
// latency, and applies the range, saturation and counter rules.
module tb_wave_sum_tree;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int OUT_W    = 16;
  localparam int LAT      = 3;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        in_valid  = 1'b0;
  logic [63:0] samples   = '0;
  logic [3:0]  ch_enable = '0;
  logic        sat_en    = 1'b0;
  logic        clr_ovf   = 1'b0;
  logic        out_valid;
  logic [15:0] result;
  logic        overflow;
  logic [7:0]  ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wave_sum_tree #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W)
  ) u_dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .samples   (samples),
    .ch_enable (ch_enable),
    .sat_en    (sat_en),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  // ---------------- reference model ----------------
  function automatic longint f_sum(input logic [63:0] smp, input logic [3:0] en);
    longint s;
    logic signed [15:0] v;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      v = smp[k*16 +: 16];
      if (en[k]) s += longint'(v);
    end
    return s;
  endfunction

  function automatic bit f_oor(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  function automatic logic [15:0] f_res(input longint s, input bit sat);
    if (!f_oor(s) || !sat) return s[15:0];
    return (s > 0) ? 16'h7fff : 16'h8000;
  endfunction

  bit          dv   [LAT];
  longint      ds   [LAT];
  bit          dsat [LAT];
  logic        m_vld = 1'b0;
  logic [15:0] m_res = '0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        dv[k]   <= 1'b0;
        ds[k]   <= 0;
        dsat[k] <= 1'b0;
      end
      m_vld <= 1'b0;
      m_res <= '0;
      m_ovf <= 1'b0;
      m_cnt <= '0;
    end else begin
      dv[0]   <= in_valid;
      ds[0]   <= f_sum(samples, ch_enable);
      dsat[0] <= sat_en;
      for (int k = 1; k < LAT; k++) begin
        dv[k]   <= dv[k-1];
        ds[k]   <= ds[k-1];
        dsat[k] <= dsat[k-1];
      end
      m_vld <= dv[LAT-1];
      if (dv[LAT-1]) m_res <= f_res(ds[LAT-1], dsat[LAT-1]);
      if (dv[LAT-1] && f_oor(ds[LAT-1])) begin
        m_ovf <= 1'b1;
        m_cnt <= clr_ovf ? 8'd1 : ((m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1);
      end else if (clr_ovf) begin
        m_ovf <= 1'b0;
        m_cnt <= 8'd0;
      end
    end
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] s0, input logic [15:0] s1,
                          input logic [15:0] s2, input logic [15:0] s3,
                          input logic [3:0] en, input logic sat);
    samples   = {s3, s2, s1, s0};
    ch_enable = en;
    sat_en    = sat;
    in_valid  = 1'b1;
  endtask

  // Accept one beat, then advance until its output is visible.
  task automatic send_one(input logic [15:0] v, input logic [3:0] en, input logic sat);
    set_beat(v, v, v, v, en, sat);
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, result, overflow, ovf_count} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, result, overflow, ovf_count});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, result, overflow, ovf_count} !== {m_vld, m_res, m_ovf, m_cnt}) begin
      n_fail++;
      $display("FAIL reset_idle: got %h required %h", {out_valid, result, overflow, ovf_count},
               {m_vld, m_res, m_ovf, m_cnt});
    end
  endtask

  task automatic test_single_beat();
    set_beat(16'd1000, 16'd1000, 16'd1000, 16'd1000, 4'hf, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      n_checks++;
      if (out_valid !== (c == LAT)) begin
        n_fail++;
        $display("FAIL single_pulse_c%0d: got %b required %b", c, out_valid, (c == LAT));
      end
    end
    n_checks++;
    if (result !== 16'd4000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result: got %0d/%b required 4000/0", $signed(result), overflow);
    end
  endtask

  task automatic test_overflow_modes();
    send_one(16'd16000, 4'hf, 1'b1);
    n_checks++;
    if ({out_valid, result, overflow, ovf_count} !== {1'b1, 16'h7fff, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL ovf_sat: got %h required %h", {out_valid, result, overflow, ovf_count},
               {1'b1, 16'h7fff, 1'b1, 8'd1});
    end
    send_one(16'd16000, 4'hf, 1'b0);
    n_checks++;
    if ({out_valid, result, overflow, ovf_count} !== {1'b1, 16'hfa00, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL ovf_wrap: got %h required %h", {out_valid, result, overflow, ovf_count},
               {1'b1, 16'hfa00, 1'b1, 8'd2});
    end
  endtask

  task automatic test_neg_clear();
    send_one(16'h8000, 4'hf, 1'b1);
    n_checks++;
    if (result !== 16'h8000 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL neg_sat: got %h/%b required 8000/1", result, overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || ovf_count !== 8'd0) begin
      n_fail++;
      $display("FAIL clear: got %b/%0d required 0/0", overflow, ovf_count);
    end
  endtask

  task automatic test_back_to_back();
    set_beat(16'd5, 16'd30000, 16'd30000, 16'd30000, 4'b0001, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    n_checks++;
    if ({out_valid, result, overflow} !== {1'b1, 16'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL mask: got %b/%0d/%b required 1/5/0", out_valid, result, overflow);
    end
    for (int b = 1; b <= 3; b++) begin
      set_beat(b[15:0], b[15:0], b[15:0], b[15:0], 4'hf, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      tick();
      n_checks++;
      if (out_valid !== (b <= 3) || result !== 16'((b <= 3 ? b : 3) * 4)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %b/%0d required %b/%0d", b, out_valid, result,
                 (b <= 3), (b <= 3 ? b : 3) * 4);
      end
    end
  endtask

  task automatic test_count_saturate();
    set_beat(16'd16000, 16'd16000, 16'd16000, 16'd16000, 4'hf, 1'b1);
    for (int c = 0; c < 300; c++) begin
      tick();
      n_checks++;
      if ({out_valid, result, overflow, ovf_count} !== {m_vld, m_res, m_ovf, m_cnt}) begin
        n_fail++;
        $display("FAIL cnt_run_%0d: got %h required %h", c,
                 {out_valid, result, overflow, ovf_count}, {m_vld, m_res, m_ovf, m_cnt});
      end
    end
    in_valid = 1'b0;
    repeat (LAT) tick();
    n_checks++;
    if (ovf_count !== 8'd255 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_hold: got %0d/%b required 255/1", ovf_count, overflow);
    end
    set_beat(16'd16000, 16'd16000, 16'd16000, 16'd16000, 4'hf, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if ({out_valid, overflow, ovf_count} !== {1'b1, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL clr_vs_event: got %b/%b/%0d required 1/1/1", out_valid, overflow, ovf_count);
    end
  endtask

  task automatic test_reset_inflight();
    set_beat(16'd100, 16'd100, 16'd100, 16'd100, 4'hf, 1'b1);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, result, overflow, ovf_count} !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h required 0", {out_valid, result, overflow, ovf_count});
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({out_valid, result, overflow, ovf_count} !== 26'd0) begin
        n_fail++;
        $display("FAIL flushed_%0d: got %h required 0", c, {out_valid, result, overflow, ovf_count});
      end
    end
    set_beat(16'd7, 16'd7, 16'd7, 16'd7, 4'hf, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      n_checks++;
      if (out_valid !== (c == LAT)) begin
        n_fail++;
        $display("FAIL post_reset_c%0d: got %b required %b", c, out_valid, (c == LAT));
      end
    end
    n_checks++;
    if (result !== 16'd28) begin
      n_fail++;
      $display("FAIL post_reset_result: got %0d required 28", result);
    end
  endtask

  task automatic test_random();
    logic [15:0] v [4];
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(1, 0) == 1) v[k] = 16'($signed($urandom_range(18000, 0)) - 9000);
        else v[k] = 16'($urandom);
      end
      samples   = {v[3], v[2], v[1], v[0]};
      ch_enable = 4'($urandom);
      sat_en    = 1'($urandom);
      in_valid  = ($urandom_range(3, 0) != 0);
      clr_ovf   = ($urandom_range(7, 0) == 0);
      tick();
      n_checks++;
      if ({out_valid, result, overflow, ovf_count} !== {m_vld, m_res, m_ovf, m_cnt}) begin
        n_fail++;
        $display("FAIL random_%0d: got %h required %h", c,
                 {out_valid, result, overflow, ovf_count}, {m_vld, m_res, m_ovf, m_cnt});
      end
    end
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    for (int c = 0; c < LAT + 1; c++) begin
      tick();
      n_checks++;
      if ({out_valid, result, overflow, ovf_count} !== {m_vld, m_res, m_ovf, m_cnt}) begin
        n_fail++;
        $display("FAIL random_drain_%0d: got %h required %h", c,
                 {out_valid, result, overflow, ovf_count}, {m_vld, m_res, m_ovf, m_cnt});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_overflow_modes();
    test_neg_clear();
    test_back_to_back();
    test_count_saturate();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
